// File: rtl/cartpole_episode_ctrl.sv
// cartpole_episode_ctrl: episode sequencer wrapped around the CartPole step-compute block.
// Latency: action accept -> step request next cycle; step result -> observation next cycle; reset request -> observation 5 cycles later.
// Backpressure: observation held until i_obs_ready, step request held until i_step_valid. Define CARTPOLE_RAND_INIT_EN for LFSR-randomised initial state.
module cartpole_episode_ctrl #(
  parameter int          INPUT_BIT = 32,
  parameter int          MAX_STEPS = 500,
  parameter logic [31:0] SEED      = 32'hACE1_2024
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 i_reset_req,
  input  logic                 i_action_valid,
  output logic                 o_action_ready,
  input  logic [INPUT_BIT-1:0] i_action,
  output logic                 o_step_signal,
  output logic [INPUT_BIT-1:0] o_step_action,
  output logic [INPUT_BIT-1:0] o_step_x,
  output logic [INPUT_BIT-1:0] o_step_x_dot,
  output logic [INPUT_BIT-1:0] o_step_theta,
  output logic [INPUT_BIT-1:0] o_step_theta_dot,
  input  logic [INPUT_BIT-1:0] i_step_x,
  input  logic [INPUT_BIT-1:0] i_step_x_dot,
  input  logic [INPUT_BIT-1:0] i_step_theta,
  input  logic [INPUT_BIT-1:0] i_step_theta_dot,
  input  logic [INPUT_BIT-1:0] i_step_reward,
  input  logic [INPUT_BIT-1:0] i_step_terminated,
  input  logic                 i_step_valid,
  output logic [INPUT_BIT-1:0] o_obs_x,
  output logic [INPUT_BIT-1:0] o_obs_x_dot,
  output logic [INPUT_BIT-1:0] o_obs_theta,
  output logic [INPUT_BIT-1:0] o_obs_theta_dot,
  output logic [INPUT_BIT-1:0] o_reward,
  output logic                 o_terminated,
  output logic                 o_truncated,
  output logic                 o_obs_valid,
  input  logic                 i_obs_ready,
  output logic [15:0]          o_episode_steps
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    OBS      = 3'd2,
    WAIT_ACT = 3'd3,
    STEP     = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_STEPS);

  if (SEED == 32'h0) begin : g_seed_check
    $error("cartpole_episode_ctrl: SEED must be non-zero");
  end

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           init_cnt;
  logic                 reset_pend;
  logic [INPUT_BIT-1:0] st_x;
  logic [INPUT_BIT-1:0] st_x_dot;
  logic [INPUT_BIT-1:0] st_theta;
  logic [INPUT_BIT-1:0] st_theta_dot;
  logic [INPUT_BIT-1:0] init_word;
  logic                 act_fire;
  logic                 step_done;
  logic                 step_term;
  logic [15:0]          steps_inc;

  // A reset request in the same cycle as a handshake wins; the handshake does not complete.
  assign act_fire  = (state == WAIT_ACT) && i_action_valid && !i_reset_req;
  assign step_done = (state == STEP) && i_step_valid && !(reset_pend || i_reset_req);
  assign step_term = |i_step_terminated;
  assign steps_inc = o_episode_steps + 16'd1;

`ifdef CARTPOLE_RAND_INIT_EN
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  logic [31:0] lfsr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
    end
  end

  // Exponent 0x79 pins magnitude to [2^-6, 2^-5); sign and mantissa are random.
  assign init_word = {lfsr[31], 8'h79, lfsr[22:0]};
`else
  assign init_word = '0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      init_cnt   <= 2'd0;
      reset_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == INIT) ? init_cnt + 2'd1 : 2'd0;
      if (state == STEP) begin
        if (i_step_valid) begin
          reset_pend <= 1'b0;
        end else if (i_reset_req) begin
          reset_pend <= 1'b1;
        end
      end else begin
        reset_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_reset_req) state_nxt = INIT;
      INIT:     if (init_cnt == 2'd3) state_nxt = OBS;
      OBS: begin
        if (i_reset_req) begin
          state_nxt = INIT;
        end else if (i_obs_ready) begin
          state_nxt = (o_terminated || o_truncated) ? DONE : WAIT_ACT;
        end
      end
      WAIT_ACT: begin
        if (i_reset_req) begin
          state_nxt = INIT;
        end else if (i_action_valid) begin
          state_nxt = STEP;
        end
      end
      STEP: begin
        if (i_step_valid) begin
          state_nxt = (reset_pend || i_reset_req) ? INIT : OBS;
        end
      end
      DONE:     if (i_reset_req) state_nxt = INIT;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_obs_valid    = 1'b0;
    o_action_ready = 1'b0;
    o_step_signal  = 1'b0;
    case (state)
      OBS:      o_obs_valid    = 1'b1;
      WAIT_ACT: o_action_ready = 1'b1;
      STEP:     o_step_signal  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      st_x            <= '0;
      st_x_dot        <= '0;
      st_theta        <= '0;
      st_theta_dot    <= '0;
      o_reward        <= '0;
      o_terminated    <= 1'b0;
      o_truncated     <= 1'b0;
      o_episode_steps <= '0;
      o_step_action   <= '0;
    end else begin
      if (state == INIT) begin
        case (init_cnt)
          2'd0:    st_x         <= init_word;
          2'd1:    st_x_dot     <= init_word;
          2'd2:    st_theta     <= init_word;
          default: st_theta_dot <= init_word;
        endcase
        if (init_cnt == 2'd3) begin
          o_reward        <= '0;
          o_terminated    <= 1'b0;
          o_truncated     <= 1'b0;
          o_episode_steps <= '0;
        end
      end else if (step_done) begin
        st_x         <= i_step_x;
        st_x_dot     <= i_step_x_dot;
        st_theta     <= i_step_theta;
        st_theta_dot <= i_step_theta_dot;
        o_reward     <= i_step_reward;
        o_terminated <= step_term;
        o_truncated  <= (steps_inc == MAX_CNT) && !step_term;
        if (o_episode_steps != MAX_CNT) begin
          o_episode_steps <= steps_inc;
        end
      end
      if (act_fire) begin
        o_step_action <= {{(INPUT_BIT-1){1'b0}}, |i_action};
      end
    end
  end

  assign o_obs_x          = st_x;
  assign o_obs_x_dot      = st_x_dot;
  assign o_obs_theta      = st_theta;
  assign o_obs_theta_dot  = st_theta_dot;
  assign o_step_x         = st_x;
  assign o_step_x_dot     = st_x_dot;
  assign o_step_theta     = st_theta;
  assign o_step_theta_dot = st_theta_dot;

endmodule

// File: tb/tb_cartpole_episode_ctrl.sv
// Randomised episode bench for cartpole_episode_ctrl against a transaction-level reference model.
module tb_cartpole_episode_ctrl;

  localparam int W   = 32;
  localparam int MAX = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          i_reset_req = 1'b0;
  logic          i_action_valid = 1'b0;
  logic          o_action_ready;
  logic [W-1:0]  i_action = '0;
  logic          o_step_signal;
  logic [W-1:0]  o_step_action;
  logic [W-1:0]  o_step_x, o_step_x_dot, o_step_theta, o_step_theta_dot;
  logic [W-1:0]  i_step_x = '0, i_step_x_dot = '0, i_step_theta = '0, i_step_theta_dot = '0;
  logic [W-1:0]  i_step_reward = '0;
  logic [W-1:0]  i_step_terminated = '0;
  logic          i_step_valid = 1'b0;
  logic [W-1:0]  o_obs_x, o_obs_x_dot, o_obs_theta, o_obs_theta_dot;
  logic [W-1:0]  o_reward;
  logic          o_terminated;
  logic          o_truncated;
  logic          o_obs_valid;
  logic          i_obs_ready = 1'b0;
  logic [15:0]   o_episode_steps;

  cartpole_episode_ctrl #(
    .INPUT_BIT(W),
    .MAX_STEPS(MAX),
    .SEED(32'hACE1_2024)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .i_reset_req(i_reset_req),
    .i_action_valid(i_action_valid),
    .o_action_ready(o_action_ready),
    .i_action(i_action),
    .o_step_signal(o_step_signal),
    .o_step_action(o_step_action),
    .o_step_x(o_step_x),
    .o_step_x_dot(o_step_x_dot),
    .o_step_theta(o_step_theta),
    .o_step_theta_dot(o_step_theta_dot),
    .i_step_x(i_step_x),
    .i_step_x_dot(i_step_x_dot),
    .i_step_theta(i_step_theta),
    .i_step_theta_dot(i_step_theta_dot),
    .i_step_reward(i_step_reward),
    .i_step_terminated(i_step_terminated),
    .i_step_valid(i_step_valid),
    .o_obs_x(o_obs_x),
    .o_obs_x_dot(o_obs_x_dot),
    .o_obs_theta(o_obs_theta),
    .o_obs_theta_dot(o_obs_theta_dot),
    .o_reward(o_reward),
    .o_terminated(o_terminated),
    .o_truncated(o_truncated),
    .o_obs_valid(o_obs_valid),
    .i_obs_ready(i_obs_ready),
    .o_episode_steps(o_episode_steps)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_st [4];
  logic [31:0] m_reward;
  bit          m_term;
  bit          m_trunc;
  int          m_steps;
  logic [31:0] prev_init_x;
  bit          have_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic check_obs(input bit words);
    chk("obs_valid", o_obs_valid, 1);
    chk("obs_no_action_ready", o_action_ready, 0);
    if (words) begin
      chk("obs_x", o_obs_x, m_st[0]);
      chk("obs_x_dot", o_obs_x_dot, m_st[1]);
      chk("obs_theta", o_obs_theta, m_st[2]);
      chk("obs_theta_dot", o_obs_theta_dot, m_st[3]);
    end
    chk("reward", o_reward, m_reward);
    chk("terminated", o_terminated, m_term);
    chk("truncated", o_truncated, m_trunc);
    chk("episode_steps", o_episode_steps, m_steps);
  endtask

  task automatic check_step_words();
    chk("step_x", o_step_x, m_st[0]);
    chk("step_x_dot", o_step_x_dot, m_st[1]);
    chk("step_theta", o_step_theta, m_st[2]);
    chk("step_theta_dot", o_step_theta_dot, m_st[3]);
  endtask

  // Entered at the first INIT cycle; a reset request mid-INIT must not restart it.
  task automatic run_init();
    for (int k = 0; k < 4; k++) begin
      chk("init_busy", {o_obs_valid, o_action_ready, o_step_signal}, 0);
      if (k == 1) i_reset_req = 1'($urandom_range(0, 1));
      tick();
      i_reset_req = 1'b0;
    end
    m_reward = '0;
    m_term   = 1'b0;
    m_trunc  = 1'b0;
    m_steps  = 0;
`ifdef CARTPOLE_RAND_INIT_EN
    chk("init_exp_x", o_obs_x[30:23], 8'h79);
    chk("init_exp_x_dot", o_obs_x_dot[30:23], 8'h79);
    chk("init_exp_theta", o_obs_theta[30:23], 8'h79);
    chk("init_exp_theta_dot", o_obs_theta_dot[30:23], 8'h79);
    if (have_prev) chk("init_differs", (o_obs_x != prev_init_x) ? 1 : 0, 1);
    prev_init_x = o_obs_x;
    have_prev   = 1'b1;
    m_st[0] = o_obs_x;
    m_st[1] = o_obs_x_dot;
    m_st[2] = o_obs_theta;
    m_st[3] = o_obs_theta_dot;
    check_obs(1'b0);
`else
    for (int i = 0; i < 4; i++) m_st[i] = '0;
    check_obs(1'b1);
`endif
  endtask

  task automatic req_to_init(input bit with_ready, input bit with_action);
    i_reset_req    = 1'b1;
    i_obs_ready    = with_ready;
    i_action_valid = with_action;
    tick();
    i_reset_req    = 1'b0;
    i_obs_ready    = 1'b0;
    i_action_valid = 1'b0;
    run_init();
  endtask

  task automatic obs_handshake(output bit done);
    int d;
    d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      i_step_valid = 1'($urandom_range(0, 1));
      i_step_x     = $urandom;
      i_step_reward = $urandom;
      tick();
      i_step_valid = 1'b0;
      check_obs(1'b1);
    end
    i_obs_ready = 1'b1;
    tick();
    i_obs_ready = 1'b0;
    done = m_term || m_trunc;
    if (done) begin
      for (int i = 0; i < 3; i++) begin
        chk("done_no_ready", o_action_ready, 0);
        chk("done_no_obs", o_obs_valid, 0);
        i_action_valid = 1'b1;
        tick();
        i_action_valid = 1'b0;
      end
    end else begin
      chk("obs_to_wait_act", o_action_ready, 1);
    end
  endtask

  task automatic do_step(input logic [31:0] act, input int lat, input bit abort,
                         input logic [31:0] n0, input logic [31:0] n1,
                         input logic [31:0] n2, input logic [31:0] n3,
                         input logic [31:0] rw, input logic [31:0] tw);
    int d;
    int nlat;
    nlat = (abort && lat < 2) ? 2 : lat;
    d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("wait_act_ready", o_action_ready, 1);
      chk("no_early_step", o_step_signal, 0);
    end
    i_action_valid = 1'b1;
    i_action       = act;
    tick();
    i_action_valid = 1'b0;
    i_action       = $urandom;
    chk("step_signal_rise", o_step_signal, 1);
    chk("step_action", o_step_action, (act != 0) ? 1 : 0);
    check_step_words();
    if (abort) i_reset_req = 1'b1;
    for (int c = 1; c < nlat; c++) begin
      tick();
      i_reset_req = 1'b0;
      chk("step_hold", o_step_signal, 1);
      check_step_words();
    end
    i_step_valid      = 1'b1;
    i_step_x          = n0;
    i_step_x_dot      = n1;
    i_step_theta      = n2;
    i_step_theta_dot  = n3;
    i_step_reward     = rw;
    i_step_terminated = tw;
    tick();
    i_step_valid = 1'b0;
    i_step_terminated = $urandom;
    chk("step_signal_fall", o_step_signal, 0);
    if (abort) begin
      run_init();
    end else begin
      m_st[0]  = n0;
      m_st[1]  = n1;
      m_st[2]  = n2;
      m_st[3]  = n3;
      m_reward = rw;
      m_term   = (tw != 0);
      m_steps  = m_steps + 1;
      m_trunc  = (m_steps == MAX) && !m_term;
      check_obs(1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done;
    repeat (3) tick();
    areset = 1'b0;
    chk("rst_obs_valid", o_obs_valid, 0);
    chk("rst_action_ready", o_action_ready, 0);
    chk("rst_step_signal", o_step_signal, 0);
    chk("rst_obs_x", o_obs_x, 0);
    chk("rst_reward", o_reward, 0);
    chk("rst_flags", {o_terminated, o_truncated}, 0);
    chk("rst_steps", o_episode_steps, 0);
    chk("rst_step_action", o_step_action, 0);
    tick();
    chk("idle_stays", {o_obs_valid, o_action_ready}, 0);
    tick();
    req_to_init(1'b0, 1'b0);

    // Directed: known state, 7-cycle step latency, then termination.
    obs_handshake(done);
    do_step(32'h5, 7, 1'b0, 32'hBDDA4B6F, 32'hBE7002B9, 32'h3E53E72E, 32'h3F5F1AFC, 32'h3F800000, 32'h0);
    obs_handshake(done);
    do_step(32'h0, 3, 1'b0, 32'h3C000000, 32'hBC000000, 32'h3D000000, 32'hBD000000, 32'h3F800000, 32'h0);
    obs_handshake(done);
    do_step(32'h1, 1, 1'b0, 32'h40000000, 32'h0, 32'h3E800000, 32'h0, 32'h3F800000, 32'h1);
    chk("term_flag", o_terminated, 1);
    obs_handshake(done);
    chk("term_done", done, 1);

    // Directed: truncation after MAX non-terminating steps.
    req_to_init(1'b0, 1'b0);
    for (int s = 0; s < MAX; s++) begin
      obs_handshake(done);
      do_step($urandom, 2, 1'b0, $urandom, $urandom, $urandom, $urandom, 32'h3F800000, 32'h0);
    end
    chk("trunc_flag", o_truncated, 1);
    chk("trunc_steps", o_episode_steps, MAX);
    obs_handshake(done);
    chk("trunc_done", done, 1);

    // Directed: reset request while a step is in flight.
    req_to_init(1'b0, 1'b0);
    obs_handshake(done);
    do_step(32'h1, 2, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h3F800000, 32'h0);
    obs_handshake(done);
    do_step(32'h1, 5, 1'b1, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h3F800000, 32'h0);
    chk("abort_steps", o_episode_steps, 0);
    chk("abort_reward", o_reward, 0);

    for (int ep = 0; ep < 40; ep++) begin
      req_to_init(1'b0, 1'b0);
      for (int it = 0; it < 10; it++) begin
        if ($urandom_range(0, 11) == 0) begin
          req_to_init(1'b1, 1'b0);
          continue;
        end
        obs_handshake(done);
        if (done) break;
        if ($urandom_range(0, 11) == 0) begin
          req_to_init(1'b0, 1'b1);
          continue;
        end
        do_step(($urandom_range(0, 1) != 0) ? $urandom : 32'h0,
                $urandom_range(1, 8), ($urandom_range(0, 7) == 0),
                $urandom, $urandom, $urandom, $urandom, $urandom,
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, 255) : 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
